// File: rtl/fifo_pkg.sv
// Shared helpers for the N-deep FIFO: derived widths and wrap-around pointer increment.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: indexes 0..depth-1, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Wrap at depth-1 rather than at a power of two so any depth works.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_n_deep_if.sv
// Guarded-method bundle for fifo_n_deep: enq/deq/first with __ENA/__RDY plus occupancy.
interface fifo_n_deep_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  import fifo_pkg::*;

  localparam int unsigned CW = cnt_width(DEPTH);

  logic             enq__ENA;
  logic [WIDTH-1:0] enq_v;
  logic             enq__RDY;
  logic             deq__ENA;
  logic             deq__RDY;
  logic [WIDTH-1:0] first;
  logic             first__RDY;
  logic [CW-1:0]    count;

  // Producer/consumer side.
  modport master (
    output enq__ENA, enq_v, deq__ENA,
    input  enq__RDY, deq__RDY, first, first__RDY, count
  );

  // FIFO side.
  modport slave (
    input  enq__ENA, enq_v, deq__ENA,
    output enq__RDY, deq__RDY, first, first__RDY, count
  );

endinterface

// File: rtl/fifo_n_deep_mem.sv
// WIDTH x DEPTH register file: one synchronous write port, one combinational read port, no reset.
module fifo_n_deep_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [ptr_width(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]              wdata_i,
  input  logic [ptr_width(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]              rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage holds stale data across reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_n_deep.sv
// fifo_n_deep: WIDTH x DEPTH guarded FIFO with occupancy count and concurrent enq/deq.
// Define FIFO_PIPE_EN to let a full FIFO accept enq in the same cycle as a deq.
module fifo_n_deep
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic         CLK,
  input  logic         nRST,
  fifo_n_deep_if.slave io
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0]    rp_q, rp_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             not_empty, not_full;
  logic             enq_rdy, deq_rdy;
  logic             enq_e, deq_e;
  logic [WIDTH-1:0] rdata;

  // Guards derive from occupancy; pipe mode also lets a concurrent deq free a slot.
  always_comb begin
    not_empty = (cnt_q != '0);
    not_full  = (cnt_q != CW'(DEPTH));
    deq_rdy   = not_empty;
`ifdef FIFO_PIPE_EN
    enq_rdy   = not_full | io.deq__ENA;
`else
    enq_rdy   = not_full;
`endif
    enq_e     = io.enq__ENA & enq_rdy;
    deq_e     = io.deq__ENA & deq_rdy;
  end

  // Pointer and occupancy next state.
  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (enq_e) begin
      wp_d = PW'(ptr_inc(32'(wp_q), DEPTH));
    end
    if (deq_e) begin
      rp_d = PW'(ptr_inc(32'(rp_q), DEPTH));
    end
    unique case ({enq_e, deq_e})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  fifo_n_deep_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (enq_e),
    .waddr_i (wp_q),
    .wdata_i (io.enq_v),
    .raddr_i (rp_q),
    .rdata_o (rdata)
  );

  // Head is read straight from storage; no bypass from enq_v.
  assign io.first      = rdata;
  assign io.first__RDY = deq_rdy;
  assign io.deq__RDY   = deq_rdy;
  assign io.enq__RDY   = enq_rdy;
  assign io.count      = cnt_q;

endmodule

// File: tb/tb_fifo_n_deep.sv
// Scoreboard bench for fifo_n_deep: DEPTH=4 and DEPTH=3 instances, WIDTH=8, directed vectors.
module tb_fifo_n_deep;

`ifdef FIFO_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct {
    int   cnt;
    logic erdy;
    logic drdy;
  } st_t;

  logic CLK;
  logic nRST;
  bit   done;

  int vectors;
  int miscompares;

  st_t        st4_q[$];
  st_t        st3_q[$];
  logic [7:0] dq4[$];
  logic [7:0] dq3[$];

  st_t        s4, s3;
  logic [7:0] x4, x3;

  fifo_n_deep_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  fifo_n_deep_if #(.WIDTH(8), .DEPTH(3)) if3 ();

  fifo_n_deep #(.WIDTH(8), .DEPTH(4)) u_dut4 (.CLK(CLK), .nRST(nRST), .io(if4));
  fifo_n_deep #(.WIDTH(8), .DEPTH(3)) u_dut3 (.CLK(CLK), .nRST(nRST), .io(if3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before 100000");
    $fatal(1, "watchdog");
  end

  // One cycle of stimulus; cnt is the hand-derived occupancy before this cycle's edge.
  task automatic cyc(input bit u3, input logic e, input logic [7:0] v, input logic d,
                     input bit acc, input int cnt);
    st_t s;
    int  dep;
    dep    = u3 ? 3 : 4;
    s.cnt  = cnt;
    s.drdy = (cnt != 0);
    s.erdy = (cnt != dep) || (PIPE && d);
    @(posedge CLK);
    #1;
    if4.enq__ENA = u3 ? 1'b0 : e;
    if4.enq_v    = u3 ? 8'h00 : v;
    if4.deq__ENA = u3 ? 1'b0 : d;
    if3.enq__ENA = u3 ? e : 1'b0;
    if3.enq_v    = u3 ? v : 8'h00;
    if3.deq__ENA = u3 ? d : 1'b0;
    if (u3) begin
      st3_q.push_back(s);
      if (acc) dq3.push_back(v);
    end else begin
      st4_q.push_back(s);
      if (acc) dq4.push_back(v);
    end
  endtask

  initial begin
    nRST = 1'b0;
    done = 1'b0;
    if4.enq__ENA = 1'b0; if4.enq_v = 8'h00; if4.deq__ENA = 1'b0;
    if3.enq__ENA = 1'b0; if3.enq_v = 8'h00; if3.deq__ENA = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // reset state
    cyc(0, 0, 8'h00, 0, 0, 0);
    // fill to full, fifth enq refused
    cyc(0, 1, 8'h11, 0, 1, 0);
    cyc(0, 1, 8'h22, 0, 1, 1);
    cyc(0, 1, 8'h33, 0, 1, 2);
    cyc(0, 1, 8'h44, 0, 1, 3);
    cyc(0, 1, 8'h55, 0, 0, 4);
    cyc(0, 0, 8'h00, 0, 0, 4);
    // drain in order, then deq on empty is ignored
    cyc(0, 0, 8'h00, 1, 0, 4);
    cyc(0, 0, 8'h00, 1, 0, 3);
    cyc(0, 0, 8'h00, 1, 0, 2);
    cyc(0, 0, 8'h00, 1, 0, 1);
    cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    // simultaneous enq+deq at count 2, ten cycles to wrap both pointers
    cyc(0, 1, 8'hA0, 0, 1, 0);
    cyc(0, 1, 8'hA1, 0, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'(8'hA2 + i), 1, 1, 2);
    cyc(0, 0, 8'h00, 1, 0, 2);
    cyc(0, 0, 8'h00, 1, 0, 1);
    cyc(0, 0, 8'h00, 0, 0, 0);
    // full with concurrent enq+deq
    cyc(0, 1, 8'hB0, 0, 1, 0);
    cyc(0, 1, 8'hB1, 0, 1, 1);
    cyc(0, 1, 8'hB2, 0, 1, 2);
    cyc(0, 1, 8'hB3, 0, 1, 3);
    cyc(0, 1, 8'hB4, 1, PIPE, 4);
    for (int c = (PIPE ? 4 : 3); c > 0; c--) cyc(0, 0, 8'h00, 1, 0, c);
    cyc(0, 0, 8'h00, 0, 0, 0);

    // DEPTH=3: seven alternations wrap the pointers 2->0
    cyc(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 8'(8'hC0 + i), 0, 1, 0);
      cyc(1, 0, 8'h00, 1, 0, 1);
    end
    cyc(1, 1, 8'hD0, 0, 1, 0);
    cyc(1, 1, 8'hD1, 0, 1, 1);
    cyc(1, 1, 8'hD2, 0, 1, 2);
    cyc(1, 1, 8'hD3, 0, 0, 3);
    cyc(1, 0, 8'h00, 1, 0, 3);
    cyc(1, 0, 8'h00, 1, 0, 2);
    cyc(1, 0, 8'h00, 1, 0, 1);
    cyc(1, 0, 8'h00, 0, 0, 0);

    @(posedge CLK);
    #1;
    if4.enq__ENA = 1'b0; if4.deq__ENA = 1'b0;
    if3.enq__ENA = 1'b0; if3.deq__ENA = 1'b0;
    repeat (2) @(posedge CLK);
    #1 done = 1'b1;
  end

  // Monitor: status compared every scheduled cycle, data compared on each accepted deq.
  always @(negedge CLK) begin
    if (st4_q.size() != 0) begin
      s4 = st4_q.pop_front();
      vectors++;
      if (int'(if4.count) != s4.cnt || if4.enq__RDY !== s4.erdy ||
          if4.deq__RDY !== s4.drdy || if4.first__RDY !== s4.drdy) begin
        miscompares++;
        $display("FAIL status4 t=%0t: count=%0d enq_rdy=%b deq_rdy=%b first_rdy=%b, required count=%0d enq_rdy=%b deq_rdy=%b",
                 $time, if4.count, if4.enq__RDY, if4.deq__RDY, if4.first__RDY, s4.cnt, s4.erdy, s4.drdy);
      end
    end
    if (st3_q.size() != 0) begin
      s3 = st3_q.pop_front();
      vectors++;
      if (int'(if3.count) != s3.cnt || if3.enq__RDY !== s3.erdy ||
          if3.deq__RDY !== s3.drdy || if3.first__RDY !== s3.drdy) begin
        miscompares++;
        $display("FAIL status3 t=%0t: count=%0d enq_rdy=%b deq_rdy=%b first_rdy=%b, required count=%0d enq_rdy=%b deq_rdy=%b",
                 $time, if3.count, if3.enq__RDY, if3.deq__RDY, if3.first__RDY, s3.cnt, s3.erdy, s3.drdy);
      end
    end
    if (if4.deq__ENA && if4.deq__RDY === 1'b1) begin
      vectors++;
      if (dq4.size() == 0) begin
        miscompares++;
        $display("FAIL deq4 t=%0t: dequeued first=%h, required no dequeue (scoreboard empty)", $time, if4.first);
      end else begin
        x4 = dq4.pop_front();
        if (if4.first !== x4) begin
          miscompares++;
          $display("FAIL data4 t=%0t: first=%h, required %h", $time, if4.first, x4);
        end
      end
    end
    if (if3.deq__ENA && if3.deq__RDY === 1'b1) begin
      vectors++;
      if (dq3.size() == 0) begin
        miscompares++;
        $display("FAIL deq3 t=%0t: dequeued first=%h, required no dequeue (scoreboard empty)", $time, if3.first);
      end else begin
        x3 = dq3.pop_front();
        if (if3.first !== x3) begin
          miscompares++;
          $display("FAIL data3 t=%0t: first=%h, required %h", $time, if3.first, x3);
        end
      end
    end
    if (done) begin
      vectors++;
      if (dq4.size() != 0 || dq3.size() != 0) begin
        miscompares++;
        $display("FAIL leftover: %0d/%0d entries never dequeued, required 0/0", dq4.size(), dq3.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

endmodule
